// File: rtl/mem_cmd_port_xfer.sv
// Memory command port: decodes a bus header, gathers address and length bytes,
// hands a descriptor to the memory FSM, then runs a byte-counted data transfer and ack.
module mem_cmd_port_xfer #(
    parameter int         ADDR_BYTES     = 3,
    parameter int         LEN_W          = 8,
    parameter logic [1:0] MEM_ID         = 2'b00,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_bus_valid,
    output logic                    out_bus_ready,
    input  logic [7:0]              in_bus_data,
    output logic                    out_bus_valid,
    input  logic                    in_bus_ready,
    output logic [7:0]              out_bus_data,
    output logic                    out_fsm_cmd_valid,
    input  logic                    in_fsm_cmd_ready,
    output logic [8*ADDR_BYTES-1:0] out_fsm_addr,
    output logic [LEN_W-1:0]        out_fsm_len,
    output logic [1:0]              out_fsm_opcode,
    output logic                    out_fsm_enc,
    output logic                    out_fsm_wvalid,
    input  logic                    in_fsm_wready,
    output logic [7:0]              out_fsm_wdata,
    input  logic                    in_fsm_rvalid,
    output logic                    out_fsm_rready,
    input  logic [7:0]              in_fsm_rdata,
    output logic                    out_ack_req,
    output logic [1:0]              out_ack_id,
    input  logic                    in_ack_grant,
    output logic                    out_busy,
    output logic                    out_err_timeout
);

    localparam int AW   = 8 * ADDR_BYTES;
    localparam int BC_W = $clog2(ADDR_BYTES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_RD_KEY  = 2'b00;
    localparam logic [1:0] OP_RD_TEXT = 2'b01;
    localparam logic [1:0] OP_WR_RES  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_CMD,
        S_XFER,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        opcode_q, opcode_d;
    logic              enc_q, enc_d;
    logic [LEN_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              hdr_rdy_q, hdr_rdy_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              ack_req_q, ack_req_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic in_xfer, xfer_wr, xfer_rd;
    logic hdr_hs, xfer_hs, hdr_accept;

    // Data phase is a pure pass-through; leaving XFER on the last byte gates further handshakes.
    assign in_xfer = (state_q == S_XFER);
    assign xfer_wr = in_xfer && (opcode_q == OP_WR_RES);
    assign xfer_rd = in_xfer && (opcode_q != OP_WR_RES);

    assign out_bus_valid  = xfer_rd & in_fsm_rvalid;
    assign out_bus_data   = xfer_rd ? in_fsm_rdata : 8'h00;
    assign out_fsm_rready = xfer_rd & in_bus_ready;
    assign out_fsm_wvalid = xfer_wr & in_bus_valid;
    assign out_fsm_wdata  = xfer_wr ? in_bus_data : 8'h00;
    assign out_bus_ready  = hdr_rdy_q | (xfer_wr & in_fsm_wready);

    assign hdr_hs  = hdr_rdy_q & in_bus_valid;
    assign xfer_hs = (xfer_rd & in_fsm_rvalid & in_bus_ready)
                   | (xfer_wr & in_bus_valid & in_fsm_wready);

    // Reads match on the source field, writes on the destination field.
    assign hdr_accept =
        (((in_bus_data[1:0] == OP_RD_KEY) || (in_bus_data[1:0] == OP_RD_TEXT))
            && (in_bus_data[3:2] == MEM_ID))
        || ((in_bus_data[1:0] == OP_WR_RES) && (in_bus_data[5:4] == MEM_ID));

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case infers a latch.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        opcode_d   = opcode_q;
        enc_d      = enc_q;
        xfer_cnt_d = xfer_cnt_q;
        wd_d       = wd_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hdr_hs && hdr_accept) begin
                    opcode_d   = in_bus_data[1:0];
                    enc_d      = in_bus_data[7];
                    byte_cnt_d = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (hdr_hs) begin
                    for (int k = 0; k < ADDR_BYTES; k++) begin
                        if (byte_cnt_q == BC_W'(k)) addr_d[8*k +: 8] = in_bus_data;
                    end
                    if (byte_cnt_q == BC_W'(ADDR_BYTES - 1)) state_d = S_LEN;
                    else byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_LEN: begin
                if (hdr_hs) begin
                    len_d   = LEN_W'(in_bus_data);
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (in_fsm_cmd_ready) begin
                    xfer_cnt_d = '0;
                    wd_d       = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                // A handshake in the expiry cycle takes priority over the abort.
                if (xfer_hs) begin
                    wd_d = '0;
                    if (xfer_cnt_q == len_q) state_d = S_ACK;
                    else xfer_cnt_d = xfer_cnt_q + 1'b1;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ACK: begin
                if (in_ack_grant) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        hdr_rdy_d   = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_LEN);
        cmd_valid_d = (state_d == S_CMD);
        ack_req_d   = (state_d == S_ACK);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            opcode_q    <= '0;
            enc_q       <= 1'b0;
            xfer_cnt_q  <= '0;
            wd_q        <= '0;
            hdr_rdy_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            ack_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge values.
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            opcode_q    <= opcode_d;
            enc_q       <= enc_d;
            xfer_cnt_q  <= xfer_cnt_d;
            wd_q        <= wd_d;
            hdr_rdy_q   <= hdr_rdy_d;
            cmd_valid_q <= cmd_valid_d;
            ack_req_q   <= ack_req_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign out_fsm_cmd_valid = cmd_valid_q;
    assign out_fsm_addr      = addr_q;
    assign out_fsm_len       = len_q;
    assign out_fsm_opcode    = opcode_q;
    assign out_fsm_enc       = enc_q;
    assign out_ack_req       = ack_req_q;
    assign out_ack_id        = ack_req_q ? MEM_ID : 2'b00;
    assign out_busy          = busy_q;
    assign out_err_timeout   = err_q;

endmodule
